// File: rtl/seq_csa_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: two multiplier bits per cycle are
// folded into a redundant sum/carry pair, then resolved by one final add.
module seq_csa_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int PW    = 2 * WIDTH;
    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPRESS,
        RESOLVE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     sum_q, sum_d;
    logic [PW-1:0]     carry_q, carry_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     product_q, product_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [PW-1:0]     pp0, pp1, s1, c1, c1_sh, s2, c2;

    // Two full-adder rows; carries shift up one place between rows.
    always_comb begin
        pp0   = mplier_q[0] ? mcand_q : '0;
        pp1   = mplier_q[1] ? (mcand_q << 1) : '0;
        s1    = sum_q ^ carry_q ^ pp0;
        c1    = (sum_q & carry_q) | (sum_q & pp0) | (carry_q & pp0);
        c1_sh = c1 << 1;
        s2    = s1 ^ c1_sh ^ pp1;
        c2    = (s1 & c1_sh) | (s1 & pp1) | (c1_sh & pp1);
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d  = PW'(in_a);
                    mplier_d = in_b;
                    sum_d    = '0;
                    carry_d  = '0;
                    count_d  = '0;
                    state_d  = COMPRESS;
                end
            end
            COMPRESS: begin
                sum_d    = s2;
                carry_d  = c2 << 1;
                mcand_d  = mcand_q << 2;
                mplier_d = mplier_q >> 2;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(STEPS - 1)) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                product_d = sum_q + carry_q;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the next state, so in_ready stays low through reset.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            count_q     <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;
endmodule
